mem_access_unit: RTL and testbench

Load/store initiator for the pipeline MEM stage. It accepts one load/store request at a time from EX and drives the single-port data memory: word write with WE, 16-bit word ADDR, 32-bit D, and a combinational Q read. Sub-word stores are done as a two-cycle read-modify-write. It returns a registered, aligned and extended result or a fault to WB.

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage load/store unit: access sizes, FSM states,
// the latched request record and the accept-time fault check.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } access_size_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_W,
        RMW_RD,
        RMW_WR
    } lsu_state_t;

    // Only the low 18 byte-address bits can address memory; the rest must be zero.
    typedef struct packed {
        access_size_t size;
        logic         sgn;
        logic [17:0]  addr;
        logic [31:0]  wdata;
        logic [4:0]   rd;
    } lsu_req_t;

    // Misalignment, illegal size, or an address outside the implemented memory.
    function automatic logic access_fault(access_size_t size, logic [31:0] addr,
                                          int unsigned mem_words);
        logic f;
        f = 1'b0;
        case (size)
            SZ_ILL:  f = 1'b1;
            SZ_HALF: f = addr[0];
            SZ_WORD: f = |addr[1:0];
            default: f = 1'b0;
        endcase
        if (|addr[31:18]) f = 1'b1;
        if (32'(addr[17:2]) >= mem_words) f = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
// Purely combinational.
module lsu_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0]  ld_word_i,
    input  logic [1:0]   ld_off_i,
    input  access_size_t ld_size_i,
    input  logic         ld_signed_i,
    output logic [31:0]  ld_data_o,
    input  logic [31:0]  st_old_i,
    input  logic [31:0]  st_wdata_i,
    input  logic [1:0]   st_off_i,
    input  access_size_t st_size_i,
    output logic [31:0]  st_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and zero/sign-extend it to a full word.
    always_comb begin
        byte_sel  = ld_word_i[{ld_off_i, 3'b000} +: 8];
        half_sel  = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = ld_word_i;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = {{24{ld_signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data_o = {{16{ld_signed_i & half_sel[15]}}, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

    // Replace only the addressed lanes of the old word with the store data.
    always_comb begin
        st_word_o = st_old_i;
        case (st_size_i)
            SZ_BYTE: st_word_o[{st_off_i, 3'b000} +: 8] = st_wdata_i[7:0];
            SZ_HALF: begin
                if (st_off_i[1]) st_word_o[31:16] = st_wdata_i[15:0];
                else             st_word_o[15:0]  = st_wdata_i[15:0];
            end
            SZ_WORD: st_word_o = st_wdata_i;
            default: st_word_o = st_old_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving a single-port word memory.
// Sub-word stores use a read-modify-write pair of cycles.
// Optional macro MEM_ACCESS_UNIT_PERF_EN adds load/store/fault response counters.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    output logic                  resp_fault,
    output logic [4:0]            resp_rd,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
`ifdef MEM_ACCESS_UNIT_PERF_EN
    ,
    output logic [31:0]           perf_loads,
    output logic [31:0]           perf_stores,
    output logic [31:0]           perf_faults
`endif
);

    lsu_state_t   state_q, state_d;
    lsu_req_t     req_q, req_d;
    logic [31:0]  merge_q, merge_d;
    logic         resp_valid_q, resp_valid_d;
    logic         resp_fault_q, resp_fault_d;
    logic [4:0]   resp_rd_q, resp_rd_d;
    logic [31:0]  resp_data_q, resp_data_d;

    access_size_t req_size_e;
    logic         accept;
    logic         acc_fault;
    logic [31:0]  ld_data;
    logic [31:0]  st_word;

    assign req_size_e = access_size_t'(req_size);
    assign accept     = req_valid && req_ready;
    assign acc_fault  = access_fault(req_size_e, req_addr, MEM_WORDS);

    // The request register only changes on a good accept, so mem_addr holds in IDLE
    // and is not disturbed by faulting requests.
    assign mem_addr = ADDR_WIDTH'(req_q.addr[17:2]);

    lsu_lane_align u_align (
        .ld_word_i   (mem_q),
        .ld_off_i    (req_q.addr[1:0]),
        .ld_size_i   (req_q.size),
        .ld_signed_i (req_q.sgn),
        .ld_data_o   (ld_data),
        .st_old_i    (merge_q),
        .st_wdata_i  (req_q.wdata),
        .st_off_i    (req_q.addr[1:0]),
        .st_size_i   (req_q.size),
        .st_word_o   (st_word)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: faults never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !acc_fault) begin
                    if (!req_we)                 state_d = LOAD;
                    else if (req_size_e == SZ_WORD) state_d = STORE_W;
                    else                         state_d = RMW_RD;
                end
            end
            RMW_RD:  state_d = RMW_WR;
            LOAD,
            STORE_W,
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: write enable comes straight from state so reset kills it at once.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        mem_we    = 1'b0;
        mem_d     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            STORE_W: begin
                mem_we = 1'b1;
                mem_d  = req_q.wdata;
            end
            RMW_WR: begin
                mem_we = 1'b1;
                mem_d  = st_word;
            end
            default: ;
        endcase
    end

    // Datapath next values: request latch, RMW merge capture and response.
    always_comb begin
        req_d        = req_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_data_d  = '0;
        resp_rd_d    = resp_rd_q;

        if (accept && !acc_fault) begin
            req_d.size  = req_size_e;
            req_d.sgn   = req_signed;
            req_d.addr  = req_addr[17:0];
            req_d.wdata = req_wdata;
            req_d.rd    = req_rd;
        end

        if (accept && acc_fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rd_d    = req_rd;
        end

        case (state_q)
            LOAD: begin
                resp_valid_d = 1'b1;
                resp_data_d  = ld_data;
                resp_rd_d    = req_q.rd;
            end
            RMW_RD: merge_d = mem_q;
            STORE_W,
            RMW_WR: begin
                resp_valid_d = 1'b1;
                resp_rd_d    = req_q.rd;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rd_q    <= '0;
            resp_data_q  <= '0;
        end else begin
            req_q        <= req_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rd_q    <= resp_rd_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;

`ifdef MEM_ACCESS_UNIT_PERF_EN
    logic [31:0] perf_loads_q, perf_stores_q, perf_faults_q;

    // Response counters, bumped on the edge that registers the matching response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_faults_q <= '0;
        end else begin
            if (state_q == LOAD)                         perf_loads_q  <= perf_loads_q + 32'd1;
            if (state_q == STORE_W || state_q == RMW_WR) perf_stores_q <= perf_stores_q + 32'd1;
            if (accept && acc_fault)                     perf_faults_q <= perf_faults_q + 32'd1;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_faults = perf_faults_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a 1024-word behavioural memory.
// Responses are checked against a queue of expectations pushed at accept time.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_fault;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_d, mem_q;
    logic        busy;
`ifdef MEM_ACCESS_UNIT_PERF_EN
    logic [31:0] perf_loads, perf_stores, perf_faults;
`endif

    mem_access_unit #(.DATA_WIDTH(32), .MEM_WORDS(1024), .ADDR_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_fault (resp_fault),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_d      (mem_d),
        .mem_q      (mem_q),
        .busy       (busy)
`ifdef MEM_ACCESS_UNIT_PERF_EN
        ,
        .perf_loads (perf_loads),
        .perf_stores(perf_stores),
        .perf_faults(perf_faults)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: synchronous write, combinational read.
    logic [31:0] tb_mem [0:1023];
    logic        mem_clear;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= '0;
        end else if (mem_we && mem_addr < 16'd1024) begin
            tb_mem[mem_addr[9:0]] <= mem_d;
        end
    end
    assign mem_q = (mem_addr < 16'd1024) ? tb_mem[mem_addr[9:0]] : '0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        fault;
        logic [31:0] data;
    } vec_t;

    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, I = 2'd3;

    int   total = 0;
    int   bad   = 0;
    int   we_count = 0;
    vec_t sb [$];

    function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                                logic [31:0] wdata, logic [4:0] rd, logic fault,
                                logic [31:0] data);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.rd = rd; v.fault = fault; v.data = data;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the request until accepted, queue its expected response, pass the accept edge.
    task automatic accept(input vec_t v);
        int unsigned n = 0;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rd     = v.rd;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: addr %h never accepted", v.addr);
        end else begin
            sb.push_back(v);
        end
        tick();
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    // Response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) we_count++;
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: rd %0d data %h", resp_rd, resp_data);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("resp_fault", resp_fault, e.fault);
                chk("resp_rd",    resp_rd,    e.rd);
                chk("resp_data",  resp_data,  e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl [21];
    int   we_snap;

    initial begin
        tbl[0]  = mk(1, W, 0, 32'h20,  32'h8000FF7F, 6,  0, 32'h0);
        tbl[1]  = mk(0, H, 1, 32'h22,  32'h0,        7,  0, 32'hFFFF8000);
        tbl[2]  = mk(0, B, 0, 32'h20,  32'h0,        8,  0, 32'h0000007F);
        tbl[3]  = mk(0, B, 1, 32'h21,  32'h0,        9,  0, 32'hFFFFFFFF);
        tbl[4]  = mk(0, H, 0, 32'h20,  32'h0,        10, 0, 32'h0000FF7F);
        tbl[5]  = mk(0, B, 1, 32'h23,  32'h0,        11, 0, 32'hFFFFFF80);
        tbl[6]  = mk(0, B, 0, 32'h23,  32'h0,        12, 0, 32'h00000080);
        tbl[7]  = mk(0, W, 1, 32'h20,  32'h0,        13, 0, 32'h8000FF7F);
        tbl[8]  = mk(1, H, 0, 32'h22,  32'hCAFE1234, 14, 0, 32'h0);
        tbl[9]  = mk(0, W, 0, 32'h20,  32'h0,        15, 0, 32'h1234FF7F);
        tbl[10] = mk(1, B, 0, 32'h11,  32'h00000055, 16, 0, 32'h0);
        tbl[11] = mk(0, W, 0, 32'h10,  32'h0,        17, 0, 32'h11AA5544);
        tbl[12] = mk(0, H, 1, 32'h12,  32'h0,        18, 0, 32'h000011AA);
        tbl[13] = mk(0, W, 0, 32'h13,  32'h0,        19, 1, 32'h0);
        tbl[14] = mk(1, H, 0, 32'h11,  32'hFFFF,     20, 1, 32'h0);
        tbl[15] = mk(0, W, 0, 32'h1000, 32'h0,       21, 1, 32'h0);
        tbl[16] = mk(0, I, 0, 32'h0,   32'h0,        22, 1, 32'h0);
        tbl[17] = mk(0, W, 0, 32'h40000, 32'h0,      23, 1, 32'h0);
        tbl[18] = mk(0, W, 0, 32'hFFC, 32'h0,        24, 0, 32'h0);
        tbl[19] = mk(1, W, 1, 32'hFFC, 32'hA5A5A5A5, 25, 0, 32'h0);
        tbl[20] = mk(0, B, 1, 32'hFFF, 32'h0,        26, 0, 32'hFFFFFFA5);

        rst_n = 1'b0; mem_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = W; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        repeat (3) @(posedge clk);
        mem_clear = 1'b0;
        #3 rst_n = 1'b1;
        tick();

        // Reset state.
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rd", resp_rd, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_d", mem_d, 0);

        // Word store then load with latency checks.
        accept(mk(1, W, 0, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0));
        req_valid = 1'b0;
        chk("stw_we", mem_we, 1);
        chk("stw_addr", mem_addr, 4);
        chk("stw_d", mem_d, 32'hDEADBEEF);
        chk("stw_ready", req_ready, 0);
        tick();
        chk("stw_we_drop", mem_we, 0);
        chk("stw_resp", resp_valid, 1);
        chk("stw_addr_hold", mem_addr, 4);
        accept(mk(0, W, 0, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF));
        req_valid = 1'b0;
        chk("ldw_we", mem_we, 0);
        chk("ldw_resp_early", resp_valid, 0);
        tick();
        chk("ldw_resp", resp_valid, 1);
        chk("ldw_data", resp_data, 32'hDEADBEEF);

        // Byte store read-modify-write.
        accept(mk(1, W, 0, 32'h10, 32'h11223344, 3, 0, 32'h0));
        req_valid = 1'b0;
        tick();
        accept(mk(1, B, 0, 32'h12, 32'h777777AA, 4, 0, 32'h0));
        req_valid = 1'b0;
        chk("rmw_rd_we", mem_we, 0);
        chk("rmw_rd_ready", req_ready, 0);
        tick();
        chk("rmw_wr_we", mem_we, 1);
        chk("rmw_wr_d", mem_d, 32'h11AA3344);
        chk("rmw_wr_ready", req_ready, 0);
        tick();
        chk("rmw_done_we", mem_we, 0);
        chk("rmw_done_ready", req_ready, 1);
        chk("rmw_mem", tb_mem[4], 32'h11AA3344);

        // Fault response appears the cycle after accept.
        accept(mk(0, I, 0, 32'h10, 32'h0, 5, 1, 32'h0));
        req_valid = 1'b0;
        chk("flt_valid", resp_valid, 1);
        chk("flt_fault", resp_fault, 1);
        chk("flt_ready", req_ready, 1);
        chk("flt_we", mem_we, 0);
        tick();

        // Vector table, driven back-to-back.
        for (int i = 0; i < 21; i++) begin
            if (i == 13) we_snap = we_count;
            if (i == 18) chk("fault_no_we", we_count - we_snap, 0);
            accept(tbl[i]);
        end
        req_valid = 1'b0;
        drain();

        // Reset during RMW_WR abandons the write.
        accept(mk(1, B, 0, 32'h20, 32'h000000EE, 27, 0, 32'h0));
        req_valid = 1'b0;
        tick();
        chk("rstrmw_we_before", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstrmw_we", mem_we, 0);
        chk("rstrmw_valid", resp_valid, 0);
        sb.delete();
        @(posedge clk);
        #1;
        chk("rstrmw_mem", tb_mem[8], 32'h1234FF7F);
        #2 rst_n = 1'b1;
        tick();
        chk("rstrmw_ready", req_ready, 1);
        chk("rstrmw_valid_after", resp_valid, 0);

        // Counter traffic: 3 loads, 2 stores, 1 fault.
        accept(mk(0, W, 0, 32'h20, 32'h0,        1, 0, 32'h1234FF7F));
        accept(mk(0, W, 0, 32'h10, 32'h0,        2, 0, 32'h11AA5544));
        accept(mk(0, W, 0, 32'h24, 32'h0,        3, 0, 32'h0));
        accept(mk(1, W, 0, 32'h24, 32'h01020304, 4, 0, 32'h0));
        accept(mk(1, B, 0, 32'h25, 32'h00000099, 5, 0, 32'h0));
        accept(mk(0, H, 0, 32'h21, 32'h0,        6, 1, 32'h0));
        req_valid = 1'b0;
        drain();
        tick();
`ifdef MEM_ACCESS_UNIT_PERF_EN
        chk("perf_loads",  perf_loads,  3);
        chk("perf_stores", perf_stores, 2);
        chk("perf_faults", perf_faults, 1);
`endif
        accept(mk(0, W, 0, 32'h24, 32'h0, 7, 0, 32'h01029904));
        req_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
